// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, register-index width and the pipeline stage state.
package cpu_pkg;

    localparam int REG_W = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_DIV = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM beats MEM/WB, register 0 is never forwarded.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [REG_W-1:0] src_addr,
    input  logic [N-1:0]     src_data,
    input  logic             exmem_reg_write,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic [N-1:0]     exmem_result,
    input  logic             memwb_reg_write,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic [N-1:0]     memwb_result,
    output logic [N-1:0]     fwd_data
);

    always_comb begin
        fwd_data = src_data;
        if (exmem_reg_write && (exmem_rd == src_addr) && (src_addr != '0))
            fwd_data = exmem_result;
        else if (memwb_reg_write && (memwb_rd == src_addr) && (src_addr != '0))
            fwd_data = memwb_result;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush, and operand forwarding.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     rs_data,
    input  logic [N-1:0]     rt_data,
    input  logic [N-1:0]     imm,
    input  logic [REG_W-1:0] rs_addr,
    input  logic [REG_W-1:0] rt_addr,
    input  logic [REG_W-1:0] rd_addr,
    input  logic             alu_src,
    input  logic [3:0]       alu_op,
    input  logic             sign_in,
    input  logic             reg_write_in,
    input  logic             flush,
    input  logic             exmem_reg_write,
    input  logic             memwb_reg_write,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic [N-1:0]     exmem_result,
    input  logic [N-1:0]     memwb_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_operation,
    output logic             alu_sign,
    output logic [REG_W-1:0] rd_out,
    output logic             reg_write_out,
    output logic             div_zero
);

    stage_state_t     state;
    logic [N-1:0]     held_rs_data;
    logic [N-1:0]     held_rt_data;
    logic [N-1:0]     held_imm;
    logic [REG_W-1:0] held_rs_addr;
    logic [REG_W-1:0] held_rt_addr;
    logic             held_alu_src;
    logic             held_reg_write;
    logic             capture;
    logic [N-1:0]     rt_fwd;

    assign in_ready = (state == ST_EMPTY) || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Flush wins over capture; a stalled FULL stage simply holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_EMPTY;
            held_rs_data   <= '0;
            held_rt_data   <= '0;
            held_imm       <= '0;
            held_rs_addr   <= '0;
            held_rt_addr   <= '0;
            rd_out         <= '0;
            held_alu_src   <= 1'b0;
            alu_operation  <= '0;
            alu_sign       <= 1'b0;
            held_reg_write <= 1'b0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else if (capture) begin
            state          <= ST_FULL;
            held_rs_data   <= rs_data;
            held_rt_data   <= rt_data;
            held_imm       <= imm;
            held_rs_addr   <= rs_addr;
            held_rt_addr   <= rt_addr;
            rd_out         <= rd_addr;
            held_alu_src   <= alu_src;
            alu_operation  <= alu_op;
            alu_sign       <= sign_in;
            held_reg_write <= reg_write_in;
        end else if (out_ready) begin
            state <= ST_EMPTY;
        end
    end

    fwd_mux #(.N(N)) u_fwd_a (
        .src_addr        (held_rs_addr),
        .src_data        (held_rs_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (alu_a)
    );

    fwd_mux #(.N(N)) u_fwd_b (
        .src_addr        (held_rt_addr),
        .src_data        (held_rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (rt_fwd)
    );

    assign alu_b         = held_alu_src ? held_imm : rt_fwd;
    assign out_valid     = (state == ST_FULL);
    assign reg_write_out = out_valid && held_reg_write;
    assign div_zero      = out_valid && (alu_operation == ALU_DIV) && (alu_b == '0);

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table for capture/forwarding, hand sequences for stall, flush and reset.
module tb_id_ex_stage;

    localparam int N = 32;

    typedef struct {
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic        alu_src;
        logic [3:0]  alu_op;
        logic        sign;
        logic        reg_write;
        logic        ex_rw;
        logic [4:0]  ex_rd;
        logic [31:0] ex_res;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_res;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_div0;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  rs_data, rt_data, imm;
    logic [4:0]    rs_addr, rt_addr, rd_addr;
    logic          alu_src;
    logic [3:0]    alu_op;
    logic          sign_in;
    logic          reg_write_in;
    logic          flush;
    logic          exmem_reg_write, memwb_reg_write;
    logic [4:0]    exmem_rd, memwb_rd;
    logic [N-1:0]  exmem_result, memwb_result;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  alu_a, alu_b;
    logic [3:0]    alu_operation;
    logic          alu_sign;
    logic [4:0]    rd_out;
    logic          reg_write_out;
    logic          div_zero;

    int compared = 0;
    int mismatched = 0;
    vec_t vecs [10];

    always #5 clk = ~clk;

    id_ex_stage #(.N(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .rs_data         (rs_data),
        .rt_data         (rt_data),
        .imm             (imm),
        .rs_addr         (rs_addr),
        .rt_addr         (rt_addr),
        .rd_addr         (rd_addr),
        .alu_src         (alu_src),
        .alu_op          (alu_op),
        .sign_in         (sign_in),
        .reg_write_in    (reg_write_in),
        .flush           (flush),
        .exmem_reg_write (exmem_reg_write),
        .memwb_reg_write (memwb_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_rd        (memwb_rd),
        .exmem_result    (exmem_result),
        .memwb_result    (memwb_result),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_operation   (alu_operation),
        .alu_sign        (alu_sign),
        .rd_out          (rd_out),
        .reg_write_out   (reg_write_out),
        .div_zero        (div_zero)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rs_data         = v.rs_data;
        rt_data         = v.rt_data;
        imm             = v.imm;
        rs_addr         = v.rs_addr;
        rt_addr         = v.rt_addr;
        rd_addr         = v.rd_addr;
        alu_src         = v.alu_src;
        alu_op          = v.alu_op;
        sign_in         = v.sign;
        reg_write_in    = v.reg_write;
        exmem_reg_write = v.ex_rw;
        exmem_rd        = v.ex_rd;
        exmem_result    = v.ex_res;
        memwb_reg_write = v.wb_rw;
        memwb_rd        = v.wb_rd;
        memwb_result    = v.wb_res;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 4'h0, 1'b0, 1'b0,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 1'b0};
        vecs[1] = '{32'h11, 32'h22, 32'd0, 5'd3, 5'd4, 5'd8, 1'b0, 4'h1, 1'b1, 1'b1,
                    1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hAA, 32'h22, 1'b0};
        vecs[2] = '{32'h11, 32'h22, 32'd0, 5'd3, 5'd4, 5'd8, 1'b0, 4'h1, 1'b1, 1'b1,
                    1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hBB, 32'h22, 1'b0};
        vecs[3] = '{32'h0, 32'h33, 32'd0, 5'd0, 5'd9, 5'd1, 1'b0, 4'h2, 1'b0, 1'b1,
                    1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE, 32'h0, 32'h33, 1'b0};
        vecs[4] = '{32'h44, 32'h55, 32'h1234, 5'd10, 5'd5, 5'd2, 1'b1, 4'h0, 1'b0, 1'b0,
                    1'b1, 5'd5, 32'h77, 1'b0, 5'd0, 32'd0, 32'h44, 32'h1234, 1'b0};
        vecs[5] = '{32'h10, 32'h20, 32'd0, 5'd11, 5'd6, 5'd4, 1'b0, 4'h4, 1'b0, 1'b1,
                    1'b1, 5'd7, 32'h99, 1'b1, 5'd6, 32'h66, 32'h10, 32'h66, 1'b0};
        vecs[6] = '{32'h50, 32'h60, 32'd0, 5'd12, 5'd13, 5'd5, 1'b1, 4'h3, 1'b1, 1'b1,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h50, 32'h0, 1'b1};
        vecs[7] = '{32'h50, 32'h60, 32'd0, 5'd12, 5'd13, 5'd5, 1'b0, 4'h3, 1'b1, 1'b0,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h50, 32'h60, 1'b0};
        vecs[8] = '{32'h50, 32'h60, 32'd0, 5'd15, 5'd14, 5'd6, 1'b0, 4'h3, 1'b0, 1'b1,
                    1'b1, 5'd14, 32'h0, 1'b0, 5'd0, 32'd0, 32'h50, 32'h0, 1'b1};
        vecs[9] = '{32'h1, 32'h70, 32'd0, 5'd20, 5'd21, 5'd31, 1'b0, 4'h8, 1'b0, 1'b0,
                    1'b1, 5'd20, 32'hC0, 1'b1, 5'd20, 32'hD0, 32'hC0, 32'h70, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        applyStimulus('{32'hDEAD, 32'hBEEF, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 4'h5, 1'b1, 1'b1,
                        1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0});
        #2;
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset reg_write_out", {31'd0, reg_write_out}, 32'd0);
        checkOutput("reset alu_operation", {28'd0, alu_operation}, 32'd0);
        checkOutput("reset rd_out", {27'd0, rd_out}, 32'd0);
        checkOutput("reset alu_a", alu_a, 32'd0);
        checkOutput("reset div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back captures with downstream always ready.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            in_valid = 1'b1;
            out_ready = 1'b1;
            tick();
            checkOutput($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("vec%0d alu_a", i), alu_a, vecs[i].exp_a);
            checkOutput($sformatf("vec%0d alu_b", i), alu_b, vecs[i].exp_b);
            checkOutput($sformatf("vec%0d alu_operation", i), {28'd0, alu_operation}, {28'd0, vecs[i].alu_op});
            checkOutput($sformatf("vec%0d alu_sign", i), {31'd0, alu_sign}, {31'd0, vecs[i].sign});
            checkOutput($sformatf("vec%0d rd_out", i), {27'd0, rd_out}, {27'd0, vecs[i].rd_addr});
            checkOutput($sformatf("vec%0d reg_write_out", i), {31'd0, reg_write_out}, {31'd0, vecs[i].reg_write});
            checkOutput($sformatf("vec%0d div_zero", i), {31'd0, div_zero}, {31'd0, vecs[i].exp_div0});
        end

        // Drain: nothing new, downstream ready.
        in_valid = 1'b0;
        tick();
        checkOutput("drain out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("drain reg_write_out", {31'd0, reg_write_out}, 32'd0);

        // Stall for three cycles with changing inputs.
        applyStimulus('{32'h100, 32'h200, 32'h0, 5'd16, 5'd17, 5'd9, 1'b0, 4'h6, 1'b1, 1'b1,
                        1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0});
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rs_data = 32'h1000 + c;
            rt_data = 32'h2000 + c;
            rd_addr = 5'(c + 20);
            alu_op = 4'h2;
            tick();
            checkOutput($sformatf("stall%0d in_ready", c), {31'd0, in_ready}, 32'd0);
            checkOutput($sformatf("stall%0d out_valid", c), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("stall%0d alu_a", c), alu_a, 32'h100);
            checkOutput($sformatf("stall%0d alu_b", c), alu_b, 32'h200);
            checkOutput($sformatf("stall%0d rd_out", c), {27'd0, rd_out}, 32'd9);
            checkOutput($sformatf("stall%0d alu_operation", c), {28'd0, alu_operation}, 32'h6);
        end
        out_ready = 1'b1;
        rs_data = 32'h300;
        rt_data = 32'h400;
        rd_addr = 5'd12;
        tick();
        checkOutput("unstall alu_a", alu_a, 32'h300);
        checkOutput("unstall alu_b", alu_b, 32'h400);
        checkOutput("unstall rd_out", {27'd0, rd_out}, 32'd12);
        checkOutput("unstall out_valid", {31'd0, out_valid}, 32'd1);

        // Flush beats a simultaneous capture.
        flush = 1'b1;
        in_valid = 1'b1;
        tick();
        checkOutput("flush out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush reg_write_out", {31'd0, reg_write_out}, 32'd0);
        checkOutput("flush in_ready", {31'd0, in_ready}, 32'd1);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        checkOutput("post-flush out_valid", {31'd0, out_valid}, 32'd0);

        // Divide-by-zero indication disappears once the stage empties.
        applyStimulus(vecs[6]);
        in_valid = 1'b1;
        tick();
        checkOutput("div0 held", {31'd0, div_zero}, 32'd1);
        in_valid = 1'b0;
        tick();
        checkOutput("div0 empty", {31'd0, div_zero}, 32'd0);

        // Reset in the middle of a stall.
        applyStimulus(vecs[1]);
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        checkOutput("prereset out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("prereset in_ready", {31'd0, in_ready}, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midreset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midreset reg_write_out", {31'd0, reg_write_out}, 32'd0);
        checkOutput("midreset rd_out", {27'd0, rd_out}, 32'd0);
        checkOutput("midreset alu_operation", {28'd0, alu_operation}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("postreset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("postreset out_valid", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
